// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM rectangle-fill engine.
//   VRAM_COL_W / VRAM_ROW_W : column / row coordinate widths
//   VRAM_ADDR_W             : VRAM port A address width, {row, col}
//   COLOR_W                 : 4R/4G/4B pixel width
//   fill_state_t            : fill FSM states
//   vram_pack_addr()        : row/col to VRAM address, matching the scan reader
package vram_pkg;

   localparam int VRAM_COL_W  = 9;
   localparam int VRAM_ROW_W  = 9;
   localparam int VRAM_ADDR_W = 18;
   localparam int COLOR_W     = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLIP,
      ST_FILL,
      ST_FINISH
   } fill_state_t;

   function automatic logic [VRAM_ADDR_W-1:0] vram_pack_addr(
      input logic [VRAM_ROW_W-1:0] row,
      input logic [VRAM_COL_W-1:0] col
   );
      return {row, col};
   endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Raster row/col counter for the rectangle fill.
//   clk, rstn     : clock, async active-low reset
//   load          : load col=x0, row=y0
//   en            : advance one pixel (granted write)
//   x0            : first column, reused at every row wrap
//   y0            : first row
//   x_end, y_end  : clipped last column / row (inclusive)
//   col, row      : current pixel
//   last          : current pixel is the final one of the rectangle
module rect_scan_counter
   import vram_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic                  en,
   input  logic [VRAM_COL_W-1:0] x0,
   input  logic [VRAM_ROW_W-1:0] y0,
   input  logic [VRAM_COL_W-1:0] x_end,
   input  logic [VRAM_ROW_W-1:0] y_end,
   output logic [VRAM_COL_W-1:0] col,
   output logic [VRAM_ROW_W-1:0] row,
   output logic                  last
);

   assign last = (col == x_end) && (row == y_end);

   // Holding at the last pixel keeps row from wrapping past V_MAX.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col <= '0;
         row <= '0;
      end else if (load) begin
         col <= x0;
         row <= y0;
      end else if (en && !last) begin
         if (col == x_end) begin
            col <= x0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vram_rect_filler.sv
// Hardware rectangle-fill engine writing into VRAM port A.
//   clk, rstn            : system clock (shared with VRAM port A), async active-low reset
//   cmd_valid/cmd_ready  : command handshake; ready only while idle
//   cmd_x0, cmd_y0       : rectangle origin
//   cmd_w, cmd_h         : size in pixels, 0..512
//   cmd_color            : fill colour
//   abort                : cancel the fill in progress
//   vram_gnt             : port A granted this cycle (CPU has priority)
//   vram_we/addr/din     : port A write strobe, {row,col} address, pixel data
//   busy                 : fill in progress
//   done                 : one-cycle pulse on completion or abort
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a command, cmd_ready=1
// ST_CLIP   | compute clipped end corner, detect empty rectangles
// ST_FILL   | one pixel write per granted cycle
// ST_FINISH | done pulse, return to idle
module vram_rect_filler #(
   parameter int H_MAX   = 511,
   parameter int V_MAX   = 511,
   parameter int COLOR_W = 12
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [8:0]         cmd_x0,
   input  logic [8:0]         cmd_y0,
   input  logic [9:0]         cmd_w,
   input  logic [9:0]         cmd_h,
   input  logic [COLOR_W-1:0] cmd_color,
   input  logic               abort,
   input  logic               vram_gnt,
   output logic               vram_we,
   output logic [17:0]        vram_addr,
   output logic [COLOR_W-1:0] vram_din,
   output logic               busy,
   output logic               done
);
   import vram_pkg::*;

   fill_state_t        state;
   logic [8:0]         x0_q, y0_q, x_end_q, y_end_q;
   logic [9:0]         w_q, h_q;
   logic [COLOR_W-1:0] color_q;
   logic [8:0]         col, row;
   logic               last;

   // 11-bit sums so x0+w-1 can never wrap back into range.
   logic [10:0] x_sum, y_sum;
   logic [8:0]  x_end_c, y_end_c;
   logic        empty_c;

   assign x_sum   = {2'b00, x0_q} + {1'b0, w_q} - 11'd1;
   assign y_sum   = {2'b00, y0_q} + {1'b0, h_q} - 11'd1;
   assign x_end_c = (x_sum > 11'(H_MAX)) ? 9'(H_MAX) : x_sum[8:0];
   assign y_end_c = (y_sum > 11'(V_MAX)) ? 9'(V_MAX) : y_sum[8:0];
   assign empty_c = (w_q == 10'd0) || (h_q == 10'd0) ||
                    ({2'b00, x0_q} > 11'(H_MAX)) || ({2'b00, y0_q} > 11'(V_MAX));

   logic fill_active;
   assign fill_active = (state == ST_FILL) && !abort;

   rect_scan_counter u_scan (
      .clk   (clk),
      .rstn  (rstn),
      .load  (state == ST_CLIP),
      .en    (fill_active && vram_gnt),
      .x0    (x0_q),
      .y0    (y0_q),
      .x_end (x_end_q),
      .y_end (y_end_q),
      .col   (col),
      .row   (row),
      .last  (last)
   );

   assign cmd_ready = ~busy;
   assign vram_we   = fill_active && vram_gnt;
   assign vram_addr = vram_pack_addr(row, col);
   assign vram_din  = color_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (cmd_valid) begin
                  x0_q    <= cmd_x0;
                  y0_q    <= cmd_y0;
                  w_q     <= cmd_w;
                  h_q     <= cmd_h;
                  color_q <= cmd_color;
                  busy    <= 1'b1;
                  state   <= ST_CLIP;
               end
            end
            ST_CLIP: begin
               x_end_q <= x_end_c;
               y_end_q <= y_end_c;
               if (abort || empty_c) begin
                  done  <= 1'b1;
                  state <= ST_FINISH;
               end else begin
                  state <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (abort || (vram_gnt && last)) begin
                  done  <= 1'b1;
                  state <= ST_FINISH;
               end
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_rect_filler.sv
// Self-checking bench for vram_rect_filler: expected pixel writes are queued
// from a raster model when a command is issued and matched against the writes
// the DUT issues.
module tb_vram_rect_filler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid, cmd_ready;
   logic [8:0]  cmd_x0, cmd_y0;
   logic [9:0]  cmd_w, cmd_h;
   logic [11:0] cmd_color;
   logic        abort, vram_gnt, vram_we, busy, done;
   logic [17:0] vram_addr;
   logic [11:0] vram_din;

   logic        cmd_valid3, cmd_ready3, vram_we3, busy3, done3;
   logic [17:0] vram_addr3;
   logic [11:0] vram_din3;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int done_cnt = 0;
   int done_rel = -1;
   int last_wr_rel = -1;
   logic [30:0] exp_q[$];
   logic [30:0] obs_q[$];

   vram_rect_filler dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_color(cmd_color), .abort(abort), .vram_gnt(vram_gnt),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
      .busy(busy), .done(done)
   );

   vram_rect_filler #(.H_MAX(300), .V_MAX(511), .COLOR_W(12)) dut300 (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_color(cmd_color), .abort(abort), .vram_gnt(vram_gnt),
      .vram_we(vram_we3), .vram_addr(vram_addr3), .vram_din(vram_din3),
      .busy(busy3), .done(done3)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record what the DUT does this cycle (called at the falling edge).
   task automatic sample();
      if (vram_we) begin
         obs_q.push_back({vram_gnt, vram_addr, vram_din});
         last_wr_rel = cyc - acc_cyc;
      end
      if (done) begin
         done_cnt++;
         done_rel = cyc - acc_cyc;
      end
   endtask

   // Raster model of the expected writes, clipped at 511.
   task automatic push_rect(input int x0, input int y0, input int w, input int h,
                            input logic [11:0] color);
      for (int r = y0; r < y0 + h && r <= 511; r++)
         for (int c = x0; c < x0 + w && c <= 511; c++)
            exp_q.push_back({1'b1, 18'(r * 512 + c), color});
   endtask

   // Present a command for one cycle; returns with the CLIP cycle sampled.
   task automatic send_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [11:0] color, output bit was_ready);
      @(posedge clk); #1;
      cmd_x0 = 9'(x0); cmd_y0 = 9'(y0); cmd_w = 10'(w); cmd_h = 10'(h);
      cmd_color = color; cmd_valid = 1'b1;
      acc_cyc = cyc;
      was_ready = cmd_ready;
      @(negedge clk); sample();
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(negedge clk); sample();
   endtask

   task automatic run_until_done(input int budget, input bit toggle, output bit ok);
      int d0 = done_cnt;
      int c = 0;
      while (c < budget && done_cnt == d0) begin
         @(posedge clk); #1;
         if (toggle) vram_gnt = ~vram_gnt;
         @(negedge clk); sample();
         c++;
      end
      ok = (done_cnt != d0);
      repeat (3) begin
         @(posedge clk); #1; vram_gnt = 1'b1;
         @(negedge clk); sample();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
      total_cnt++; if (vram_we !== 1'b0) $display("FAIL reset_we got=%b want=0", vram_we); else pass_cnt++;
      total_cnt++; if (vram_addr !== 18'h0) $display("FAIL reset_addr got=%h want=0", vram_addr); else pass_cnt++;
      total_cnt++; if (vram_din !== 12'h0) $display("FAIL reset_din got=%h want=0", vram_din); else pass_cnt++;
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      bit rdy, ok;
      int d0 = done_cnt;
      push_rect(10, 20, 3, 2, 12'hF00);
      send_cmd(10, 20, 3, 2, 12'hF00, rdy);
      run_until_done(40, 1'b0, ok);
      total_cnt++; if (!rdy) $display("FAIL basic_accept_ready got=0 want=1"); else pass_cnt++;
      total_cnt++; if (!ok) $display("FAIL basic_done_timeout got=none want=done"); else pass_cnt++;
      total_cnt++; if (done_rel != 8) $display("FAIL basic_done_cycle got=%0d want=8", done_rel); else pass_cnt++;
      total_cnt++; if (done_cnt - d0 != 1) $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d0); else pass_cnt++;
      total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_write_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [30:0] o = obs_q.pop_front();
         logic [30:0] e = exp_q.pop_front();
         total_cnt++; if (o !== e) $display("FAIL basic_write got=%h want=%h", o, e); else pass_cnt++;
      end
      total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL basic_ready_after got=%b want=1", cmd_ready); else pass_cnt++;
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_stall();
      bit rdy, ok;
      push_rect(10, 20, 3, 2, 12'h0F0);
      send_cmd(10, 20, 3, 2, 12'h0F0, rdy);
      run_until_done(60, 1'b1, ok);
      total_cnt++; if (!ok) $display("FAIL stall_done_timeout got=none want=done"); else pass_cnt++;
      total_cnt++; if (done_rel != last_wr_rel + 1) $display("FAIL stall_done_cycle got=%0d want=%0d", done_rel, last_wr_rel + 1); else pass_cnt++;
      total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_write_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [30:0] o = obs_q.pop_front();
         logic [30:0] e = exp_q.pop_front();
         total_cnt++; if (o !== e) $display("FAIL stall_write(gnt,addr,din) got=%h want=%h", o, e); else pass_cnt++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_clip();
      bit rdy, ok;
      push_rect(510, 511, 4, 3, 12'h00F);
      send_cmd(510, 511, 4, 3, 12'h00F, rdy);
      run_until_done(40, 1'b0, ok);
      total_cnt++; if (!ok) $display("FAIL clip_done_timeout got=none want=done"); else pass_cnt++;
      total_cnt++; if (done_rel != 4) $display("FAIL clip_done_cycle got=%0d want=4", done_rel); else pass_cnt++;
      total_cnt++; if (obs_q.size() != 2) $display("FAIL clip_write_count got=%0d want=2", obs_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [30:0] o = obs_q.pop_front();
         logic [30:0] e = exp_q.pop_front();
         total_cnt++; if (o !== e) $display("FAIL clip_write got=%h want=%h", o, e); else pass_cnt++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_empty();
      bit rdy, ok;
      int wr3, d3rel;
      logic [17:0] last3;
      for (int k = 0; k < 2; k++) begin
         send_cmd(5, 5, (k == 0) ? 0 : 7, (k == 0) ? 7 : 0, 12'hFFF, rdy);
         run_until_done(20, 1'b0, ok);
         total_cnt++; if (!ok) $display("FAIL empty%0d_done_timeout got=none want=done", k); else pass_cnt++;
         total_cnt++; if (done_rel != 2) $display("FAIL empty%0d_done_cycle got=%0d want=2", k, done_rel); else pass_cnt++;
         total_cnt++; if (obs_q.size() != 0) $display("FAIL empty%0d_write_count got=%0d want=0", k, obs_q.size()); else pass_cnt++;
         obs_q.delete();
      end
      // H_MAX=300 instance: x0=400 is off-screen, x0=298 w=5 clips to 3 columns.
      for (int k = 0; k < 2; k++) begin
         wr3 = 0; d3rel = -1; last3 = '0;
         @(posedge clk); #1;
         cmd_x0 = (k == 0) ? 9'd400 : 9'd298; cmd_y0 = 9'd3;
         cmd_w = 10'd5; cmd_h = 10'd1; cmd_color = 12'h123;
         cmd_valid3 = 1'b1; acc_cyc = cyc;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (vram_we3) begin wr3++; last3 = vram_addr3; end
            if (done3 && d3rel < 0) d3rel = cyc - acc_cyc;
            @(posedge clk); #1; cmd_valid3 = 1'b0;
         end
         total_cnt++; if (wr3 != ((k == 0) ? 0 : 3)) $display("FAIL hmax300_%0d_write_count got=%0d want=%0d", k, wr3, (k == 0) ? 0 : 3); else pass_cnt++;
         total_cnt++; if (d3rel != ((k == 0) ? 2 : 5)) $display("FAIL hmax300_%0d_done_cycle got=%0d want=%0d", k, d3rel, (k == 0) ? 2 : 5); else pass_cnt++;
         if (k == 1) begin
            total_cnt++; if (last3 !== 18'(3 * 512 + 300)) $display("FAIL hmax300_last_addr got=%h want=%h", last3, 18'(3 * 512 + 300)); else pass_cnt++;
         end
      end
   endtask

   task automatic test_abort();
      bit rdy, ok;
      int d0 = done_cnt;
      int c = 0;
      push_rect(100, 50, 5, 1, 12'hABC);
      send_cmd(100, 50, 16, 16, 12'hABC, rdy);
      while (obs_q.size() < 5 && c < 40) begin
         @(posedge clk); #1;
         @(negedge clk); sample();
         c++;
      end
      @(posedge clk); #1; abort = 1'b1;
      @(negedge clk); sample();
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk); sample();
      run_until_done(4, 1'b0, ok);
      total_cnt++; if (done_cnt - d0 != 1) $display("FAIL abort_done_pulses got=%0d want=1", done_cnt - d0); else pass_cnt++;
      total_cnt++; if (obs_q.size() != 5) $display("FAIL abort_write_count got=%0d want=5", obs_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [30:0] o = obs_q.pop_front();
         logic [30:0] e = exp_q.pop_front();
         total_cnt++; if (o !== e) $display("FAIL abort_write got=%h want=%h", o, e); else pass_cnt++;
      end
      total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready_after got=%b want=1", cmd_ready); else pass_cnt++;
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_fill();
      bit rdy, ok;
      int c = 0;
      send_cmd(0, 0, 16, 16, 12'h555, rdy);
      while (obs_q.size() < 3 && c < 40) begin
         @(posedge clk); #1;
         @(negedge clk); sample();
         c++;
      end
      @(posedge clk); #1; rstn = 1'b0;
      #1;
      total_cnt++; if (vram_we !== 1'b0) $display("FAIL midrst_we got=%b want=0", vram_we); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", busy); else pass_cnt++;
      total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL midrst_ready got=%b want=1", cmd_ready); else pass_cnt++;
      total_cnt++; if (vram_addr !== 18'h0) $display("FAIL midrst_addr got=%h want=0", vram_addr); else pass_cnt++;
      total_cnt++; if (vram_din !== 12'h0) $display("FAIL midrst_din got=%h want=0", vram_din); else pass_cnt++;
      obs_q.delete();
      repeat (2) @(posedge clk);
      #1; rstn = 1'b1;
      repeat (10) begin
         @(negedge clk); sample();
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL midrst_writes_after got=%0d want=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      push_rect(5, 7, 1, 1, 12'h9A5);
      send_cmd(5, 7, 1, 1, 12'h9A5, rdy);
      run_until_done(20, 1'b0, ok);
      total_cnt++; if (!ok || done_rel != 3) $display("FAIL midrst_1x1_done got=%0d want=3", done_rel); else pass_cnt++;
      total_cnt++; if (obs_q.size() != 1) $display("FAIL midrst_1x1_count got=%0d want=1", obs_q.size()); else pass_cnt++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [30:0] o = obs_q.pop_front();
         logic [30:0] e = exp_q.pop_front();
         total_cnt++; if (o !== e) $display("FAIL midrst_1x1_write got=%h want=%h", o, e); else pass_cnt++;
      end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_valid3 = 1'b0;
      cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
      abort = 1'b0; vram_gnt = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_clip();
      test_empty();
      test_abort();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
